// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the two-port RAM arbiter.
// Optional conflict counter in mem_arbiter is enabled by MEM_ARB_PERF_CNT_EN.
package mem_arb_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam int unsigned DEF_ADDR_W  = 9;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned RAM_SEL_BIT = 8;

  // 2'b11 is reserved and behaves like no request.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MEM_READ) || (cmd == MEM_WRITE);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; ptr_q names the requester favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After a grant the pointer moves to the requester that was not served.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between the CPU (m0) and a loader (m1).
// Define MEM_ARB_PERF_CNT_EN to add the saturating conflict counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_grant,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic [1:0]        m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_grant,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-2:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
`ifdef MEM_ARB_PERF_CNT_EN
  input  logic              conflict_clr,
  output logic [15:0]       conflict_cnt,
`endif
  output logic              oor_flag
);

  logic              m0_valid, m1_valid;
  logic [1:0]        req, gnt;
  logic              any_gnt, in_range, ram_access;
  logic [1:0]        g_cmd;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [1:0]        rvalid_q, rvalid_d;
  logic              ram_rd_q, ram_rd_d;
  logic              oor_q, oor_d;

  assign m0_valid = is_req(m0_cmd);
  assign m1_valid = is_req(m1_cmd);
  // Masking with reset keeps grants low while reset is held.
  assign req      = {m1_valid, m0_valid} & {2{reset}};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (any_gnt),
    .gnt     (gnt)
  );

  assign any_gnt  = |gnt;
  assign m0_grant = gnt[0];
  assign m1_grant = gnt[1];

  always_comb begin
    g_cmd      = gnt[1] ? m1_cmd   : m0_cmd;
    g_addr     = gnt[1] ? m1_addr  : m0_addr;
    g_wdata    = gnt[1] ? m1_wdata : m0_wdata;
    in_range   = ~g_addr[RAM_SEL_BIT];
    ram_access = any_gnt & in_range;
    ram_write  = ram_access & (g_cmd == MEM_WRITE);
    ram_addr   = ram_access ? g_addr[ADDR_W-2:0] : '0;
    ram_din    = ram_access ? g_wdata : '0;
    rvalid_d   = gnt & {2{g_cmd == MEM_READ}};
    ram_rd_d   = in_range;
    oor_d      = oor_q | (any_gnt & ~in_range);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 2'b00;
      ram_rd_q <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      ram_rd_q <= ram_rd_d;
      oor_q    <= oor_d;
    end
  end

  // Out-of-range reads still return rvalid, but with zero data.
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = (rvalid_q[0] && ram_rd_q) ? ram_dout : '0;
  assign m1_rdata  = (rvalid_q[1] && ram_rd_q) ? ram_dout : '0;
  assign oor_flag  = oor_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (conflict_clr) begin
      conflict_d = 16'h0000;
    end else if (m0_valid && m1_valid && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_q <= 16'h0000;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  m0_cmd, m1_cmd;
  logic [8:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_grant, m1_grant, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din, ram_dout;
  logic        oor_flag;
`ifdef MEM_ARB_PERF_CNT_EN
  logic        conflict_clr;
  logic [15:0] conflict_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // RAM model plus a back-door load port used only while the DUT is in reset.
  logic [15:0] mem [256];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    else if (ld_en) mem[ld_addr] <= ld_data;
    ram_dout <= mem[ram_addr];
  end

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_cmd    (m0_cmd),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_grant  (m0_grant),
    .m0_rdata  (m0_rdata),
    .m0_rvalid (m0_rvalid),
    .m1_cmd    (m1_cmd),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_grant  (m1_grant),
    .m1_rdata  (m1_rdata),
    .m1_rvalid (m1_rvalid),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
`ifdef MEM_ARB_PERF_CNT_EN
    .conflict_clr (conflict_clr),
    .conflict_cnt (conflict_cnt),
`endif
    .oor_flag  (oor_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_cmd = 2'b00; m1_cmd = 2'b00;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_cmd = 2'b01; m0_addr = 9'h005;
    load(8'h05, 16'hABCD);
    load(8'h20, 16'h00A0);
    load(8'h21, 16'h00A1);
    load(8'h22, 16'h00A2);
    load(8'h00, 16'h5A5A);
    load(8'hFF, 16'h0000);
    checks++;
    if (m0_grant !== 1'b0 || m1_grant !== 1'b0) begin
      errors++; $display("FAIL reset_grant: got %b%b expected 00", m1_grant, m0_grant);
    end
    checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || oor_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rv0=%b rv1=%b oor=%b expected 0 0 0",
               m0_rvalid, m1_rvalid, oor_flag);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (m0_grant !== 1'b1 || m1_grant !== 1'b0 || ram_addr !== 8'h05 || ram_write !== 1'b0) begin
      errors++;
      $display("FAIL first_read_grant: got g0=%b g1=%b addr=%h wr=%b expected 1 0 05 0",
               m0_grant, m1_grant, ram_addr, ram_write);
    end
    tick();
    idle();
    #1;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 16'hABCD || m1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL first_read_data: got rv0=%b rd=%h rv1=%b expected 1 abcd 0",
               m0_rvalid, m0_rdata, m1_rvalid);
    end
    tick();
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 16'h0000) begin
      errors++; $display("FAIL rvalid_one_cycle: got rv0=%b rd=%h expected 0 0000", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp0;
    do_reset();
    m0_cmd = 2'b10; m0_addr = 9'h010; m0_wdata = 16'h1111;
    m1_cmd = 2'b10; m1_addr = 9'h011; m1_wdata = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      #1;
      checks++;
      if (m0_grant !== exp0 || m1_grant !== !exp0 || ram_write !== 1'b1 ||
          ram_addr !== (exp0 ? 8'h10 : 8'h11) || ram_din !== (exp0 ? 16'h1111 : 16'h2222)) begin
        errors++;
        $display("FAIL rr_cycle%0d: got g0=%b g1=%b wr=%b addr=%h din=%h expected g0=%b",
                 i, m0_grant, m1_grant, ram_write, ram_addr, ram_din, exp0);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (ram_write !== 1'b0 || ram_addr !== 8'h00 || ram_din !== 16'h0000) begin
      errors++;
      $display("FAIL idle_outputs: got wr=%b addr=%h din=%h expected 0 00 0000",
               ram_write, ram_addr, ram_din);
    end
    checks++;
    if (mem[8'h10] !== 16'h1111 || mem[8'h11] !== 16'h2222) begin
      errors++;
      $display("FAIL rr_ram_words: got %h %h expected 1111 2222", mem[8'h10], mem[8'h11]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        m0_cmd = 2'b01; m0_addr = 9'h020 + 9'(i);
      end else begin
        m0_cmd = 2'b00;
      end
      #1;
      checks++;
      if (m0_grant !== (i < 3) || m1_grant !== 1'b0) begin
        errors++; $display("FAIL b2b_grant%0d: got g0=%b g1=%b expected %b 0", i, m0_grant, m1_grant, (i < 3));
      end
      if (i > 0) begin
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== (16'h00A0 + 16'(i - 1))) begin
          errors++;
          $display("FAIL b2b_data%0d: got rv=%b rd=%h expected 1 %h", i, m0_rvalid, m0_rdata,
                   16'h00A0 + 16'(i - 1));
        end
      end
      tick();
    end
    checks++;
    if (m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_tail: got rv=%b expected 0", m0_rvalid);
    end
  endtask

  task automatic test_oor();
    m1_cmd = 2'b01; m1_addr = 9'h100;
    #1;
    checks++;
    if (m1_grant !== 1'b1 || m0_grant !== 1'b0 || ram_write !== 1'b0) begin
      errors++;
      $display("FAIL oor_grant: got g1=%b g0=%b wr=%b expected 1 0 0", m1_grant, m0_grant, ram_write);
    end
    tick();
    idle();
    #1;
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 16'h0000 || oor_flag !== 1'b1 || m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL oor_read: got rv1=%b rd1=%h oor=%b rv0=%b expected 1 0000 1 0",
               m1_rvalid, m1_rdata, oor_flag, m0_rvalid);
    end
    m0_cmd = 2'b10; m0_addr = 9'h1FF; m0_wdata = 16'hDEAD;
    #1;
    checks++;
    if (m0_grant !== 1'b1 || ram_write !== 1'b0) begin
      errors++; $display("FAIL oor_write: got g0=%b wr=%b expected 1 0", m0_grant, ram_write);
    end
    tick();
    idle();
    tick();
    checks++;
    if (oor_flag !== 1'b1 || mem[8'hFF] !== 16'h0000 || m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL oor_sticky: got oor=%b mem=%h rv0=%b expected 1 0000 0",
               oor_flag, mem[8'hFF], m0_rvalid);
    end
  endtask

  task automatic test_reset_inflight();
    m0_cmd = 2'b01; m0_addr = 9'h005;
    #1;
    checks++;
    if (m0_grant !== 1'b1) begin
      errors++; $display("FAIL inflight_grant: got %b expected 1", m0_grant);
    end
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 16'h0000 || oor_flag !== 1'b0) begin
      errors++;
      $display("FAIL inflight_drop: got rv0=%b rd=%h oor=%b expected 0 0000 0",
               m0_rvalid, m0_rdata, oor_flag);
    end
    tick();
    reset = 1'b1;
    m0_cmd = 2'b01; m0_addr = 9'h005;
    m1_cmd = 2'b01; m1_addr = 9'h020;
    #1;
    checks++;
    if (m0_grant !== 1'b1 || m1_grant !== 1'b0 || m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL ptr_after_reset: got g0=%b g1=%b rv0=%b expected 1 0 0", m0_grant, m1_grant, m0_rvalid);
    end
    tick();
    idle();
  endtask

`ifdef MEM_ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    conflict_clr = 1'b0;
    do_reset();
    #1;
    checks++;
    if (conflict_cnt !== 16'h0000) begin
      errors++; $display("FAIL cnt_reset: got %h expected 0000", conflict_cnt);
    end
    m0_cmd = 2'b10; m0_addr = 9'h030; m0_wdata = 16'h0001;
    m1_cmd = 2'b10; m1_addr = 9'h031; m1_wdata = 16'h0002;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (conflict_cnt !== 16'd5) begin
      errors++; $display("FAIL cnt_five: got %0d expected 5", conflict_cnt);
    end
    conflict_clr = 1'b1;
    tick();
    conflict_clr = 1'b0;
    checks++;
    if (conflict_cnt !== 16'h0000) begin
      errors++; $display("FAIL cnt_clear: got %h expected 0000", conflict_cnt);
    end
    for (int i = 0; i < 65540; i++) tick();
    idle();
    tick();
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_saturate: got %h expected ffff", conflict_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    idle();
`ifdef MEM_ARB_PERF_CNT_EN
    conflict_clr = 1'b0;
`endif
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_oor();
    test_reset_inflight();
`ifdef MEM_ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single 256-word RAM (512-word address space, addr[8]==0 selects RAM) between the CPU (m0) and a second bus master (m1, loader/DMA).
- Sits between the requesters and the RAM in the top level.
- Replaces the direct CPU-to-RAM glue logic.
- Uses round-robin grant, a one-cycle registered read-return path, and handling for out-of-range addresses.

Parameters:
- ADDR_W, 9, requester address width; MSB is the RAM-select bit (0 = RAM).
- DATA_W, 16, data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_cmd  input  2  CPU command: 00 none, 01 read, 10 write, 11 treated as none.
- m0_addr  input  ADDR_W  CPU address.
- m0_wdata  input  DATA_W  CPU write data.
- m0_grant  output  1  combinational; request accepted this cycle.
- m0_rdata  output  DATA_W  read return data.
- m0_rvalid  output  1  registered; read data valid.
- m1_cmd, m1_addr, m1_wdata, m1_grant, m1_rdata, m1_rvalid: same as m0 for requester 1.
- ram_addr  output  ADDR_W-1  RAM read/write address.
- ram_write  output  1  RAM write enable.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM synchronous read data, valid the cycle after the address.
- oor_flag  output  1  sticky; an out-of-range access occurred.

Behaviour:
- Request: cmd is 01 or 10. The requester holds cmd, addr and wdata stable until it sees grant high at a rising edge.
- Arbitration is combinational in cycle N:
  - One requester valid: it is granted.
  - Both valid: the requester selected by registered pointer rr_ptr is granted.
  - rr_ptr updates at the edge ending N to point at the non-granted requester. It holds if nothing was granted.
  - Back-to-back grants to the same master are allowed when the other is idle.
- RAM access for an in-range grant (addr[8]==0):
  - ram_addr = granted addr[7:0]; ram_din = granted wdata.
  - ram_write = 1 only for a write.
  - Write completes at the end of cycle N. There is no response pulse; grant is the completion.
- Read latency: rvalid for the granted master is high for exactly cycle N+1.
  - rdata = ram_dout in that cycle (combinational pass-through, gated by the registered owner bit).
  - rdata is 0 whenever that master's rvalid is low.
- Out-of-range grant (addr[8]==1):
  - Arbitrates normally. No RAM access: ram_write = 0.
  - A read returns rvalid in N+1 with rdata = 0.
  - oor_flag is set at the edge and stays set until reset.
- Idle cycles: ram_write = 0, ram_addr = 0, ram_din = 0.
- Throughput: one grant per cycle total. A read in N and another grant in N+1 are both legal; the rvalid and grant paths are independent.
- Reset (asynchronous assert, synchronous release):
  - rr_ptr = 0 (m0 favoured). Both rvalid = 0. oor_flag = 0.
  - An in-flight read is dropped; no rvalid follows.
  - Grants are 0 while reset is low.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN.
- When defined:
  - Adds output conflict_cnt [15:0]. It increments at each edge where both requesters were valid.
  - It saturates at 16'hFFFF and is cleared by reset.
  - Adds input conflict_clr; when high, the counter clears synchronously, with priority over increment.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - MEM_NONE = 2'b00, MEM_READ = 2'b01, MEM_WRITE = 2'b10.
  - ADDR_W, DATA_W defaults.
  - RAM_SEL_BIT = 8.
- One sub-module, rr_arb2: two-way round-robin picker holding rr_ptr.
  - Inputs req[1:0], advance. Output gnt[1:0] (one-hot or zero).
- The top level holds the datapath muxes, the rvalid/owner registers and oor_flag.

Test Plan:
- Reset low with m0 read pending -> grants 0, rvalid 0. After release, m0 read of addr 9'h005 holding 16'hABCD -> m0_grant in N, m0_rvalid in N+1 with rdata 16'hABCD, m1_rvalid 0.
- Both masters write every cycle (m0 to 9'h010, m1 to 9'h011) -> grants alternate m0, m1, m0, ... Both RAM words are written; ram_write high each cycle.
- m1 idle, m0 issues 3 consecutive reads -> three grants in three cycles, three rvalids on consecutive cycles, data in order.
- m1 read of addr 9'h100 -> m1_grant, ram_write 0, m1_rvalid next cycle with rdata 0, oor_flag sets and stays set.
- m0 read granted, reset asserted the next cycle -> no m0_rvalid, rr_ptr returns to m0.
- With MEM_ARB_PERF_CNT_EN defined: 5 contending cycles -> conflict_cnt = 5. conflict_clr -> 0. Preload near 16'hFFFF -> counter saturates.
